uart_buffered: RTL and testbench
================================

# uart_buffered

Parametrised successor to the single-byte UART peripheral, with configurable TX and RX FIFOs. Frame format is runtime-programmable: 5–8 data bits, none/even/odd parity, and 1 or 2 stop bits. RX errors are detected and reported as sticky flags. The block sits on the core's simple req/we peripheral bus, drives the board TX pin and samples the RX pin.

## Interface
- TX_DEPTH, 8: TX FIFO entries; power of two, ≥2.
- RX_DEPTH, 8: RX FIFO entries; power of two, ≥2.
- DEFAULT_BAUD, 32'd433: reset value of BAUD (50 MHz / 115200 − 1).
- clk_i  in  1  sole clock.
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- req_i  in  1  bus request.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  32  byte address; only [7:0] are decoded.
- data_i  in  32  write data.
- ready_o  out  1  constant 1; every access completes in one cycle.
- data_o  out  32  read data; combinational; 0 when there is no read.
- tx_o  out  1  serial out; idles high.
- rx_i  in  1  serial in; asynchronous.

## Operation
Register map; undecoded addresses read 0 and ignore writes:
- 0x00 CTRL (rw, reset 0).
  - [0] tx_en; [1] rx_en.
  - [3:2] data_len: 0..3 selects 5..8 bits.
  - [5:4] parity: 00 none, 01 even, 10 odd, 11 none.
  - [6] stop2.
- 0x04 STATUS.
  - [0] tx_busy (shifter active or TX FIFO non-empty).
  - [1] rx_valid (RX FIFO non-empty).
  - [2] tx_full; [3] rx_full.
  - Sticky error flags: [4] overrun, [5] parity_err, [6] frame_err. Writing 1 to a bit in [6:4] clears it.
- 0x08 BAUD (rw): clocks per bit minus 1. Writes below 7 are stored as 7.
- 0x0C TXDATA (wo): pushes data_i[7:0]. Silently dropped when the TX FIFO is full.
- 0x10 RXDATA (ro): returns the RX FIFO head in [7:0] and pops it in the same cycle. When empty, returns 0 and does not pop.
- 0x14 LEVEL (ro): [7:0] TX count, [15:8] RX count.

TX FSM: IDLE → START → DATA → PARITY (only if parity enabled) → STOP → IDLE.
- In IDLE with tx_en=1 and the FIFO non-empty: pop one entry and latch data_len, parity and stop2 for that frame.
- Data is sent LSB first. Bits above data_len are not sent.
- Parity bit: even = XOR of the data bits; odd = its inverse.
- STOP lasts one bit, or two when stop2=1.
- Clearing tx_en mid-frame finishes the current frame; no further pops occur.

RX FSM: IDLE → START → DATA → PARITY (if enabled) → STOP → IDLE.
- rx_i passes through a 2-flop synchroniser with reset value 1.
- IDLE: a falling edge with rx_en=1 loads the bit counter with BAUD/2 (mid-bit point).
- START: at mid-bit, if the line is high, treat it as a glitch and return to IDLE. Otherwise reload BAUD and continue.
- DATA and PARITY: one sample per BAUD+1 cycles.
- STOP: only the first stop bit is checked. A sampled 0 sets frame_err and the byte is discarded.
- A parity mismatch sets parity_err and the byte is discarded.
- A valid byte is pushed to the RX FIFO, zero-extended. If the FIFO is full, the byte is dropped and overrun is set.
- Clearing rx_en aborts the current frame immediately; the FSM returns to IDLE.

Simultaneous events:
- A pop and an RX push in the same cycle are both honoured, even when the FIFO is full. The count stays unchanged and no overrun occurs.
- A bus write-1-clear and a hardware set of the same flag in the same cycle: the set wins.

Reset:
- tx_o=1, data_o=0, ready_o=1.
- Both FIFOs empty; all flags 0; CTRL=0; BAUD=DEFAULT_BAUD.
- Reset mid-frame truncates the frame and forces tx_o high on the next edge.

## Timing
- A TXDATA write at edge N updates the FIFO count at N+1. If the transmitter is idle, the pop occurs at N+1 and tx_o falls at N+2.
- Frame length is (1 + data bits + parity bit + stop bits) × (BAUD+1) cycles.
- A received byte becomes visible in RXDATA and rx_valid one cycle after the first stop bit's mid-bit sample.
- RX frame error is within ±½ bit over 10 bits, given the mid-bit sampling above.
- RXDATA read: data_o is combinational in the request cycle; the pop takes effect at that cycle's edge.

## Structure
- Shared package uart_pkg holds:
  - tx_state_e and rx_state_e enums;
  - register offset localparams;
  - CTRL/STATUS bit index localparams;
  - MIN_BAUD = 7.
- One sub-module, sync_fifo #(WIDTH, DEPTH), instanced twice:
  - push/pop/full/empty/count ports;
  - first-word-fall-through head;
  - count width is $clog2(DEPTH)+1.

## Test plan
- BAUD=7, 8N1, tx_en=1, write 0xA5: tx_o pattern is 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles, tx_o falls 2 cycles after the write.
- Write 9 bytes with TX_DEPTH=8 while tx_en=0: LEVEL[7:0]=8, the 9th byte is lost. Set tx_en: exactly 8 frames are sent, then tx_busy=0.
- Loop tx_o to rx_i, 7E2 (data_len=2, parity=01, stop2=1), send 0x35: RXDATA=0x35, parity_err=0, LEVEL[15:8] goes 1→0 after the read.
- Drive an RX frame with odd parity configured but an even-parity bit: no push, parity_err=1. Write 0x20 to STATUS: parity_err=0.
- Receive RX_DEPTH+1 bytes without reading: rx_full=1, overrun=1, the first RX_DEPTH bytes are read back intact. Separately, a 3-cycle low glitch on rx_i with BAUD=15 causes no push and no error.
- Assert rst_i mid-TX-frame: tx_o=1 the next cycle, LEVEL=0, STATUS=0, BAUD reads 433.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART: FSM state encodings, register map,
// CTRL/STATUS bit positions and the parity helper used by both TX and RX.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_BAUD   = 8'h08;
  localparam logic [7:0] REG_TXDATA = 8'h0C;
  localparam logic [7:0] REG_RXDATA = 8'h10;
  localparam logic [7:0] REG_LEVEL  = 8'h14;

  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_RX_EN   = 1;
  localparam int CTRL_LEN_LSB = 2;
  localparam int CTRL_PAR_LSB = 4;
  localparam int CTRL_STOP2   = 6;

  localparam int ST_TX_BUSY   = 0;
  localparam int ST_RX_VALID  = 1;
  localparam int ST_TX_FULL   = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_PARITY    = 5;
  localparam int ST_FRAME     = 6;

  localparam logic [31:0] MIN_BAUD = 32'd7;

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == 2'b01) || (mode == 2'b10);
  endfunction

  // Only the bits actually on the wire (5..8 of them) take part in parity.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] len,
                                      input logic [1:0] mode);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - len);
    return (^(data & mask)) ^ (mode == 2'b10);
  endfunction

endpackage

// File: rtl/uart_buffered_fifo.sv
// Synchronous FIFO with first-word-fall-through head; a pop frees a slot for a
// push in the same cycle, so push+pop on a full FIFO is accepted.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_buffered.sv
// Buffered UART peripheral: register file on the req/we bus, TX/RX FIFOs and
// runtime-programmable frame format (5-8 data bits, parity, 1/2 stop bits).
//   state      | meaning
//   *_IDLE     | line idle; TX waits for tx_en + data, RX for a falling edge
//   *_START    | start bit (RX: qualified at mid-bit)
//   *_DATA     | data bits, LSB first
//   *_PARITY   | parity bit, only when parity is enabled
//   *_STOP     | stop bit(s); RX checks only the first
module uart_buffered
  import uart_pkg::*;
#(
  parameter int          TX_DEPTH     = 8,
  parameter int          RX_DEPTH     = 8,
  parameter logic [31:0] DEFAULT_BAUD = 32'd433
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        ready_o,
  output logic [31:0] data_o,
  output logic        tx_o,
  input  logic        rx_i
);
  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  localparam int RXCW = $clog2(RX_DEPTH) + 1;

  logic [7:0]  addr;
  logic        bus_wr, bus_rd;
  logic [6:0]  ctrl;
  logic [31:0] baud;
  logic        overrun, parity_err, frame_err;
  logic [2:0]  flag_clr;
  logic        unused_addr;

  logic            tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]      tx_head;
  logic [TXCW-1:0] tx_count;
  logic            rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]      rx_head;
  logic [RXCW-1:0] rx_count;

  assign ready_o     = 1'b1;
  assign addr        = addr_i[7:0];
  assign unused_addr = ^addr_i[31:8];
  assign bus_wr      = req_i && we_i;
  assign bus_rd      = req_i && !we_i;
  assign tx_push     = bus_wr && (addr == REG_TXDATA);
  assign rx_pop      = bus_rd && (addr == REG_RXDATA);
  assign flag_clr    = (bus_wr && addr == REG_STATUS) ? data_i[6:4] : 3'b000;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk_i), .rst(rst_i), .push(tx_push), .push_data(data_i[7:0]), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  // ---------------- TX ----------------
  tx_state_e   tx_state;
  logic [31:0] tx_cnt;
  logic [2:0]  tx_idx, tx_last;
  logic [7:0]  tx_shift;
  logic [1:0]  tx_len, tx_par;
  logic        tx_stop_left, tx_par_bit, tx_line, tx_busy;

  assign tx_pop  = (tx_state == TX_IDLE) && ctrl[CTRL_TX_EN] && !tx_empty;
  assign tx_last = 3'd4 + {1'b0, tx_len};
  assign tx_busy = (tx_state != TX_IDLE) || !tx_empty;

  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_shift[0];
      TX_PARITY: tx_line = tx_par_bit;
      default:   tx_line = 1'b1;
    endcase
  end

  // tx_o is registered from the state, so it trails the state by one clock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state     <= TX_IDLE;
      tx_cnt       <= '0;
      tx_idx       <= '0;
      tx_shift     <= '0;
      tx_len       <= '0;
      tx_par       <= '0;
      tx_stop_left <= 1'b0;
      tx_par_bit   <= 1'b0;
      tx_o         <= 1'b1;
    end else begin
      tx_o <= tx_line;
      if (tx_state == TX_IDLE) begin
        if (tx_pop) begin
          tx_shift     <= tx_head;
          tx_len       <= ctrl[CTRL_LEN_LSB +: 2];
          tx_par       <= ctrl[CTRL_PAR_LSB +: 2];
          tx_stop_left <= ctrl[CTRL_STOP2];
          tx_par_bit   <= parity_bit(tx_head, ctrl[CTRL_LEN_LSB +: 2], ctrl[CTRL_PAR_LSB +: 2]);
          tx_cnt       <= baud;
          tx_state     <= TX_START;
        end
      end else if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 32'd1;
      end else begin
        tx_cnt <= baud;
        case (tx_state)
          TX_START: begin
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end
          TX_DATA: begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_idx   <= tx_idx + 3'd1;
            if (tx_idx == tx_last) tx_state <= parity_enabled(tx_par) ? TX_PARITY : TX_STOP;
          end
          TX_PARITY: tx_state <= TX_STOP;
          TX_STOP: begin
            if (tx_stop_left) tx_stop_left <= 1'b0;
            else              tx_state     <= TX_IDLE;
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_e   rx_state;
  logic [31:0] rx_cnt;
  logic [2:0]  rx_idx, rx_last;
  logic [7:0]  rx_shift;
  logic [1:0]  rx_len, rx_par;
  logic        rx_par_sample, rx_s1, rx_s2, rx_prev;
  logic        rx_en, rx_stop_sample, rx_par_ok;
  logic        set_overrun, set_parity, set_frame;

  assign rx_en          = ctrl[CTRL_RX_EN];
  assign rx_last        = 3'd4 + {1'b0, rx_len};
  assign rx_stop_sample = rx_en && (rx_state == RX_STOP) && (rx_cnt == '0);
  assign rx_par_ok      = !parity_enabled(rx_par) ||
                          (rx_par_sample == parity_bit(rx_shift, rx_len, rx_par));
  assign rx_push        = rx_stop_sample && rx_s2 && rx_par_ok;
  assign set_frame      = rx_stop_sample && !rx_s2;
  assign set_parity     = rx_stop_sample && rx_s2 && !rx_par_ok;
  // Full FIFO is never empty, so a concurrent read always frees the slot.
  assign set_overrun    = rx_push && rx_full && !rx_pop;

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk_i), .rst(rst_i), .push(rx_push), .push_data(rx_shift), .pop(rx_pop),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_prev       <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_len        <= '0;
      rx_par        <= '0;
      rx_par_sample <= 1'b0;
    end else begin
      rx_s1   <= rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (!rx_en) begin
        rx_state <= RX_IDLE;
      end else if (rx_state == RX_IDLE) begin
        if (rx_prev && !rx_s2) begin
          rx_cnt   <= baud >> 1;
          rx_len   <= ctrl[CTRL_LEN_LSB +: 2];
          rx_par   <= ctrl[CTRL_PAR_LSB +: 2];
          rx_shift <= '0;
          rx_idx   <= '0;
          rx_state <= RX_START;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 32'd1;
      end else begin
        rx_cnt <= baud;
        case (rx_state)
          RX_START: rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          RX_DATA: begin
            rx_shift[rx_idx] <= rx_s2;
            rx_idx           <= rx_idx + 3'd1;
            if (rx_idx == rx_last) rx_state <= parity_enabled(rx_par) ? RX_PARITY : RX_STOP;
          end
          RX_PARITY: begin
            rx_par_sample <= rx_s2;
            rx_state      <= RX_STOP;
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl <= '0;
      baud <= DEFAULT_BAUD;
    end else if (bus_wr) begin
      if (addr == REG_CTRL) ctrl <= data_i[6:0];
      if (addr == REG_BAUD) baud <= (data_i < MIN_BAUD) ? MIN_BAUD : data_i;
    end
  end

  // Hardware set takes priority over a same-cycle write-1-clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overrun    <= (overrun    && !flag_clr[0]) || set_overrun;
      parity_err <= (parity_err && !flag_clr[1]) || set_parity;
      frame_err  <= (frame_err  && !flag_clr[2]) || set_frame;
    end
  end

  always_comb begin
    data_o = '0;
    if (bus_rd) begin
      case (addr)
        REG_CTRL:   data_o = {25'd0, ctrl};
        REG_STATUS: data_o = {25'd0, frame_err, parity_err, overrun,
                              rx_full, tx_full, !rx_empty, tx_busy};
        REG_BAUD:   data_o = baud;
        REG_RXDATA: data_o = {24'd0, rx_empty ? 8'h00 : rx_head};
        REG_LEVEL:  data_o = {16'd0, 8'(rx_count), 8'(tx_count)};
        default:    data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_buffered.sv
// Self-checking bench for uart_buffered: register vector table, TX line monitor
// with byte scoreboard, RX frame driver with read-back scoreboard.
module tb_uart_buffered;

  localparam logic [7:0] A_CTRL = 8'h00, A_STATUS = 8'h04, A_BAUD = 8'h08;
  localparam logic [7:0] A_TXDATA = 8'h0C, A_RXDATA = 8'h10, A_LEVEL = 8'h14;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [31:0] addr, wdata, rdata;
  logic        ready, tx, rx;
  logic        loop, rx_drv;

  assign rx = loop ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_buffered dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .data_i(wdata),
    .ready_o(ready), .data_o(rdata), .tx_o(tx), .rx_i(rx)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int   mon_baud = 7;
  int   mon_bits = 8;
  logic [1:0] mon_par = 2'b00;
  bit   mon_en = 1'b0;
  int   frames_seen = 0;

  typedef struct {
    logic        we;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = {24'h0, a}; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = {24'h0, a};
    #1 d = rdata;
    @(posedge clk); #1;
    req = 1'b0; addr = '0;
  endtask

  task automatic rd_check(input logic [7:0] a, input logic [31:0] mask,
                          input logic [31:0] exp, input string name);
    logic [31:0] v;
    bus_rd(a, v);
    check(name, v & mask, exp);
  endtask

  task automatic wait_status(input logic [31:0] mask, input logic [31:0] val,
                             input int max_polls, input string name);
    logic [31:0] s;
    int k;
    k = 0;
    bus_rd(A_STATUS, s);
    while (((s & mask) != val) && (k < max_polls)) begin
      bus_rd(A_STATUS, s);
      k++;
    end
    check(name, s & mask, val);
  endtask

  task automatic rx_read_check(input string name);
    logic [31:0] v;
    bus_rd(A_RXDATA, v);
    if (rx_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: got 0x%0h expected nothing queued", name, v);
    end else begin
      check(name, v, {24'h0, rx_q.pop_front()});
    end
  endtask

  task automatic drive_bit(input logic v, input int cyc);
    rx_drv = v;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] d, input int nbits, input int baudv,
                         input logic [1:0] par, input bit stop2, input bit bad_par,
                         input bit bad_stop);
    logic p;
    p = (par == 2'b10) ^ bad_par;
    @(posedge clk); #1;
    drive_bit(1'b0, baudv + 1);
    for (int i = 0; i < nbits; i++) begin
      p = p ^ d[i];
      drive_bit(d[i], baudv + 1);
    end
    if (par == 2'b01 || par == 2'b10) drive_bit(p, baudv + 1);
    drive_bit(!bad_stop, baudv + 1);
    if (stop2) drive_bit(1'b1, baudv + 1);
    rx_drv = 1'b1;
  endtask

  // Decodes frames on tx at mid-bit and scores them against tx_q.
  always begin : tx_mon
    logic [7:0] b;
    logic       exp_pb;
    @(negedge tx);
    if (mon_en) begin
      b = '0;
      repeat ((mon_baud + 1) / 2) @(posedge clk);
      #1 check("tx_start_bit", {31'd0, tx}, 32'd0);
      for (int i = 0; i < mon_bits; i++) begin
        repeat (mon_baud + 1) @(posedge clk);
        #1 b[i] = tx;
      end
      if (mon_par == 2'b01 || mon_par == 2'b10) begin
        repeat (mon_baud + 1) @(posedge clk);
        exp_pb = (^b) ^ (mon_par == 2'b10);
        #1 check("tx_parity_bit", {31'd0, tx}, {31'd0, exp_pb});
      end
      repeat (mon_baud + 1) @(posedge clk);
      #1 check("tx_stop_bit", {31'd0, tx}, 32'd1);
      frames_seen++;
      if (tx_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL tx_byte: got 0x%0h expected no frame", b);
      end else begin
        check("tx_byte", {24'h0, b}, {24'h0, tx_q.pop_front()});
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] got_wave, exp_wave;
    logic [9:0]  pat;
    logic [31:0] v;
    int          f0;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    loop = 1'b0; rx_drv = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_idle", {31'd0, tx}, 32'd1);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_data_o", rdata, 32'd0);
    rst = 1'b0;

    // Register map vectors.
    vecs.push_back('{1'b0, A_CTRL,   32'h0,         32'h0,   "ctrl_reset"});
    vecs.push_back('{1'b0, A_STATUS, 32'h0,         32'h0,   "status_reset"});
    vecs.push_back('{1'b0, A_BAUD,   32'h0,         32'd433, "baud_reset"});
    vecs.push_back('{1'b0, A_LEVEL,  32'h0,         32'h0,   "level_reset"});
    vecs.push_back('{1'b0, A_RXDATA, 32'h0,         32'h0,   "rxdata_empty"});
    vecs.push_back('{1'b1, A_BAUD,   32'd3,         32'h0,   ""});
    vecs.push_back('{1'b0, A_BAUD,   32'h0,         32'd7,   "baud_clamp_3"});
    vecs.push_back('{1'b1, A_BAUD,   32'd6,         32'h0,   ""});
    vecs.push_back('{1'b0, A_BAUD,   32'h0,         32'd7,   "baud_clamp_6"});
    vecs.push_back('{1'b1, A_BAUD,   32'd8,         32'h0,   ""});
    vecs.push_back('{1'b0, A_BAUD,   32'h0,         32'd8,   "baud_8_kept"});
    vecs.push_back('{1'b1, A_CTRL,   32'hFFFF_FF80, 32'h0,   ""});
    vecs.push_back('{1'b0, A_CTRL,   32'h0,         32'h0,   "ctrl_upper_ignored"});
    vecs.push_back('{1'b1, A_CTRL,   32'h0000_007C, 32'h0,   ""});
    vecs.push_back('{1'b0, A_CTRL,   32'h0,         32'h7C,  "ctrl_rw"});
    vecs.push_back('{1'b1, 8'h18,    32'hFFFF_FFFF, 32'h0,   ""});
    vecs.push_back('{1'b0, 8'h18,    32'h0,         32'h0,   "undecoded_read"});
    vecs.push_back('{1'b1, A_STATUS, 32'h7F,        32'h0,   ""});
    vecs.push_back('{1'b0, A_STATUS, 32'h0,         32'h0,   "status_after_w1c"});
    vecs.push_back('{1'b1, A_CTRL,   32'h0,         32'h0,   ""});
    foreach (vecs[i]) begin
      if (vecs[i].we) bus_wr(vecs[i].a, vecs[i].d);
      else begin
        bus_rd(vecs[i].a, v);
        check(vecs[i].name, v, vecs[i].exp);
      end
    end

    // 0xA5, 8N1, BAUD=7: exact waveform and latency.
    bus_wr(A_BAUD, 32'd7);
    mon_baud = 7; mon_bits = 8; mon_par = 2'b00; mon_en = 1'b1;
    bus_wr(A_CTRL, 32'h0D);
    tx_q.push_back(8'hA5);
    bus_wr(A_TXDATA, 32'hA5);
    @(posedge clk); #1;
    check("tx_a5_high_at_n1", {31'd0, tx}, 32'd1);
    pat = 10'b1101001010;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 8; j++) exp_wave[8*k + j] = pat[k];
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1 got_wave[i] = tx;
    end
    n_cmp++;
    if (got_wave !== exp_wave) begin
      n_err++;
      $display("FAIL tx_a5_wave: got 0x%0h expected 0x%0h", got_wave, exp_wave);
    end
    wait_status(32'h1, 32'h0, 50, "tx_a5_idle");

    // Nine writes into an 8-deep FIFO with tx disabled, then drain.
    bus_wr(A_CTRL, 32'h0C);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_q.push_back(8'(8'h10 + 8'(i * 7)));
      bus_wr(A_TXDATA, 32'(8'h10 + 8'(i * 7)));
    end
    rd_check(A_LEVEL, 32'hFF, 32'd8, "tx_level_full");
    rd_check(A_STATUS, 32'h7F, 32'h05, "tx_busy_full");
    f0 = frames_seen;
    bus_wr(A_CTRL, 32'h0D);
    wait_status(32'h1, 32'h0, 2000, "tx_drain_idle");
    repeat (4) @(posedge clk);
    check("tx_frame_count", frames_seen - f0, 32'd8);
    check("tx_queue_drained", tx_q.size(), 32'd0);
    rd_check(A_LEVEL, 32'hFFFF, 32'h0, "tx_level_empty");

    // Loopback 7E2 with 0x35.
    bus_wr(A_CTRL, 32'h5B);
    mon_bits = 7; mon_par = 2'b01;
    loop = 1'b1;
    tx_q.push_back(8'h35);
    rx_q.push_back(8'h35);
    bus_wr(A_TXDATA, 32'h35);
    wait_status(32'h2, 32'h2, 300, "loop_rx_valid");
    rd_check(A_LEVEL, 32'hFF00, 32'h0100, "loop_rx_level_1");
    rx_read_check("loop_rx_byte");
    rd_check(A_STATUS, 32'h70, 32'h0, "loop_no_errors");
    rd_check(A_LEVEL, 32'hFF00, 32'h0, "loop_rx_level_0");
    wait_status(32'h1, 32'h0, 100, "loop_tx_idle");
    loop = 1'b0;

    // Odd parity configured, even parity bit on the wire.
    bus_wr(A_CTRL, 32'h2E);
    send_rx(8'h5A, 8, 7, 2'b10, 1'b0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    rd_check(A_STATUS, 32'h7F, 32'h20, "parity_err_set");
    rd_check(A_LEVEL, 32'hFF00, 32'h0, "parity_no_push");
    bus_wr(A_STATUS, 32'h20);
    rd_check(A_STATUS, 32'h7F, 32'h0, "parity_err_cleared");
    rx_q.push_back(8'h5A);
    send_rx(8'h5A, 8, 7, 2'b10, 1'b0, 1'b0, 1'b0);
    wait_status(32'h2, 32'h2, 50, "odd_good_valid");
    rx_read_check("odd_good_byte");
    send_rx(8'h33, 8, 7, 2'b10, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    rd_check(A_STATUS, 32'h7F, 32'h40, "frame_err_set");
    bus_wr(A_STATUS, 32'h40);
    rd_check(A_STATUS, 32'h7F, 32'h0, "frame_err_cleared");

    // RX_DEPTH+1 bytes without reading.
    bus_wr(A_CTRL, 32'h0E);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) rx_q.push_back(8'(8'hC0 + 8'(i * 3)));
      send_rx(8'(8'hC0 + 8'(i * 3)), 8, 7, 2'b00, 1'b0, 1'b0, 1'b0);
    end
    repeat (4) @(posedge clk);
    rd_check(A_STATUS, 32'h7F, 32'h1A, "rx_full_overrun");
    rd_check(A_LEVEL, 32'hFFFF, 32'h0800, "rx_level_full");
    for (int i = 0; i < 8; i++) rx_read_check("rx_overrun_data");
    rd_check(A_STATUS, 32'h7F, 32'h10, "overrun_sticky");
    bus_wr(A_STATUS, 32'h10);
    rd_check(A_STATUS, 32'h7F, 32'h0, "overrun_cleared");

    // Short glitch at BAUD=15, then a real frame at that rate.
    bus_wr(A_BAUD, 32'd15);
    @(posedge clk); #1;
    drive_bit(1'b0, 3);
    rx_drv = 1'b1;
    repeat (40) @(posedge clk);
    rd_check(A_STATUS, 32'h7F, 32'h0, "glitch_no_error");
    rd_check(A_LEVEL, 32'hFFFF, 32'h0, "glitch_no_push");
    rx_q.push_back(8'h96);
    send_rx(8'h96, 8, 15, 2'b00, 1'b0, 1'b0, 1'b0);
    wait_status(32'h2, 32'h2, 60, "baud15_valid");
    rx_read_check("baud15_byte");

    // Reset in the middle of a TX frame.
    mon_en = 1'b0;
    bus_wr(A_BAUD, 32'd7);
    bus_wr(A_CTRL, 32'h0D);
    bus_wr(A_TXDATA, 32'h00);
    bus_wr(A_TXDATA, 32'h00);
    repeat (30) @(posedge clk);
    #1 check("pre_reset_tx_low", {31'd0, tx}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_tx_forced_high", {31'd0, tx}, 32'd1);
    rst = 1'b0;
    rd_check(A_LEVEL, 32'hFFFF_FFFF, 32'h0, "reset_level");
    rd_check(A_STATUS, 32'hFFFF_FFFF, 32'h0, "reset_status");
    rd_check(A_BAUD, 32'hFFFF_FFFF, 32'd433, "reset_baud");
    rd_check(A_CTRL, 32'hFFFF_FFFF, 32'h0, "reset_ctrl");
    repeat (20) @(posedge clk);
    #1 check("reset_tx_stays_high", {31'd0, tx}, 32'd1);

    check("rx_queue_empty_end", rx_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
